// File: rtl/apb_regs_pkg.sv
// Shared types and helpers for the APB4 register bridge.
// Holds the FSM state encoding and the address alignment check.
package apb_regs_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_st_e;

    localparam int DEF_DATA_WD = 32;
    localparam int STRB_WD     = DEF_DATA_WD / 8;

    function automatic logic is_aligned(
        input logic [31:0] addr,
        input int          strb_wd
    );
        return (addr & 32'(strb_wd - 1)) == 32'd0;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating WAIT-cycle counter for the APB register bridge.
// expired_o flags the last allowed WAIT cycle; tied low when disabled.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    if (TIMEOUT_CYC == 0) begin : g_off
        logic unused_in;
        assign unused_in = ^{clk_i, rst_ni, clr_i, en_i};
        assign expired_o = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(TIMEOUT_CYC + 1);
        localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYC);
        localparam logic [CW-1:0] CEXP = CW'(TIMEOUT_CYC - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        // Clear outside WAIT, count idle WAIT cycles, hold at the cap.
        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i && cnt_q != CMAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Counter register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired_o = (cnt_q == CEXP);
    end

endmodule

// File: rtl/apb4_regs_bridge.sv
// APB4 slave front-end driving a req/ack register backend.
// Adds range/alignment errors, wait states and a backend timeout.
module apb4_regs_bridge
    import apb_regs_pkg::*;
#(
    parameter int          ADDR_WD     = 12,
    parameter int          DATA_WD     = 32,
    parameter int unsigned ADDR_LIMIT  = 'h100,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic [ADDR_WD-1:0]   paddr,
    input  logic                 pwrite,
    input  logic [DATA_WD-1:0]   pwdata,
    input  logic [DATA_WD/8-1:0] pstrb,
    output logic [DATA_WD-1:0]   prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic                 reg_req,
    output logic                 reg_we,
    output logic [ADDR_WD-1:0]   reg_addr,
    output logic [DATA_WD-1:0]   reg_wdata,
    output logic [DATA_WD/8-1:0] reg_be,
    input  logic                 reg_ack,
    input  logic [DATA_WD-1:0]   reg_rdata,
    input  logic                 reg_err
);

    localparam int SW = DATA_WD / 8;
    localparam logic [ADDR_WD-1:0] AMASK = ~ADDR_WD'(SW - 1);

    apb_st_e              state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_WD-1:0]   addr_q, addr_d;
    logic [DATA_WD-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]        be_q, be_d;
    logic [DATA_WD-1:0]   rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic setup, illegal, in_wait, in_resp, expired;

    assign setup   = psel & ~penable;
    assign illegal = (32'(paddr) >= 32'(ADDR_LIMIT))
                   | ~is_aligned(32'(paddr), SW);
    assign in_wait = (state_q == WAIT) & psel;
    assign in_resp = (state_q == RESP) & psel & penable;

    apb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk_i    (pclk),
        .rst_ni   (preset_n),
        .clr_i    (state_q != WAIT),
        .en_i     (in_wait & ~reg_ack),
        .expired_o(expired)
    );

    // Next state, request capture and response latching.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    we_d    = pwrite;
                    addr_d  = paddr & AMASK;
                    wdata_d = pwdata;
                    be_d    = pwrite ? pstrb : '1;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (pwrite && pstrb == '0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (reg_ack) begin
                    rdata_d = we_q ? '0 : reg_rdata;
                    err_d   = reg_err;
                    state_d = RESP;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, capture and response registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign reg_req   = in_wait;
    assign reg_we    = we_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_be    = be_q;
    assign prdata    = rdata_q;
    assign pready    = in_resp;
    assign pslverr   = in_resp & err_q;

endmodule

// File: tb/tb_apb4_regs_bridge.sv
// Directed bench for apb4_regs_bridge.
// Vector table plus hand-written corner sequences.
module tb_apb4_regs_bridge;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        reg_req, reg_we;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        reg_err;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb4_regs_bridge dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .reg_req  (reg_req),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_be   (reg_be),
        .reg_ack  (reg_ack),
        .reg_rdata(reg_rdata),
        .reg_err  (reg_err)
    );

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          dly;
        logic [31:0] rdata;
        logic        rerr;
        int          exp_lat;
        int          exp_req;
        logic        exp_err;
        logic [31:0] exp_prdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            psel    = 1'b0;
            penable = 1'b0;
            @(negedge pclk);
        end
    endtask

    task automatic xfer(input string nm, input vec_t v);
        int  lat;
        int  reqc;
        int  widx;
        bit  done;
        lat  = 0;
        reqc = 0;
        widx = 0;
        done = 1'b0;
        @(posedge pclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = v.addr;
        pwrite  = v.wr;
        pwdata  = v.wdata;
        pstrb   = v.strb;
        reg_ack = 1'b0;
        @(negedge pclk);
        chk({nm, "_setup_rdy"}, 32'(pready), 32'd0);
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge pclk);
            #1;
            penable = 1'b1;
            reg_ack = 1'b0;
            #1;
            if (reg_req) begin
                if (widx == v.dly) begin
                    reg_ack   = 1'b1;
                    reg_rdata = v.rdata;
                    reg_err   = v.rerr;
                end
                widx++;
            end
            @(negedge pclk);
            if (reg_req) begin
                reqc++;
                if (reqc == 1) begin
                    chk({nm, "_be"}, 32'(reg_be), 32'(v.exp_be));
                    chk({nm, "_addr"}, 32'(reg_addr),
                        32'(v.addr & 12'hFFC));
                    chk({nm, "_we"}, 32'(reg_we), 32'(v.wr));
                    if (v.wr)
                        chk({nm, "_wdata"}, reg_wdata, v.wdata);
                end
            end
            if (pready) begin
                done = 1'b1;
                lat  = n;
            end
        end
        reg_ack = 1'b0;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "_reqcyc"}, 32'(reqc), 32'(v.exp_req));
        chk({nm, "_slverr"}, 32'(pslverr), 32'(v.exp_err));
        chk({nm, "_prdata"}, prdata, v.exp_prdata);
    endtask

    initial begin
        preset_n  = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        pstrb     = '0;
        reg_ack   = 1'b0;
        reg_rdata = '0;
        reg_err   = 1'b0;

        //        addr    wr    wdata         strb  dly rdata         rerr lat req err prdata        be
        tv[0] = '{12'h004, 1'b1, 32'h0000_0005, 4'hF, 0, 32'h0,        1'b0, 2, 1, 1'b0, 32'h0,        4'hF};
        tv[1] = '{12'h010, 1'b0, 32'h0,         4'h0, 3, 32'hCAFE_F00D, 1'b0, 5, 4, 1'b0, 32'hCAFE_F00D, 4'hF};
        tv[2] = '{12'h100, 1'b0, 32'h0,         4'h0, 0, 32'h0,        1'b0, 1, 0, 1'b1, 32'h0,        4'h0};
        tv[3] = '{12'h006, 1'b1, 32'h1234_0000, 4'hF, 0, 32'h0,        1'b0, 1, 0, 1'b1, 32'h0,        4'h0};
        tv[4] = '{12'h008, 1'b1, 32'hAAAA_5555, 4'h0, 0, 32'h0,        1'b0, 1, 0, 1'b0, 32'h0,        4'h0};
        tv[5] = '{12'h020, 1'b0, 32'h0,         4'h0, -1, 32'h0,       1'b0, 17, 16, 1'b1, 32'h0,      4'hF};
        tv[6] = '{12'h0FC, 1'b1, 32'h0BAD_F00D, 4'h3, 1, 32'h0,        1'b1, 3, 2, 1'b1, 32'h0,        4'h3};
        tv[7] = '{12'h0FF, 1'b0, 32'h0,         4'h0, 0, 32'h0,        1'b0, 1, 0, 1'b1, 32'h0,        4'h0};
        tv[8] = '{12'h014, 1'b0, 32'h0,         4'h0, 0, 32'h1234_5678, 1'b0, 2, 1, 1'b0, 32'h1234_5678, 4'hF};
        tv[9] = '{12'h00C, 1'b1, 32'h0000_00FF, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 2, 1, 1'b0, 32'h0,       4'hF};

        repeat (3) @(negedge pclk);
        chk("rst_ctl", 32'({pready, pslverr, reg_req, reg_we}), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        chk("rst_be", 32'(reg_be), 32'd0);
        #1;
        preset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            xfer($sformatf("v%0d", i), tv[i]);
            idle(1);
        end

        // Stray acks after a timed-out read must be ignored.
        xfer("tmo", tv[5]);
        @(posedge pclk);
        #1;
        psel      = 1'b0;
        penable   = 1'b0;
        reg_ack   = 1'b1;
        reg_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk($sformatf("stray%0d_req", i), 32'(reg_req), 32'd0);
            chk($sformatf("stray%0d_rdy", i), 32'(pready), 32'd0);
            @(posedge pclk);
            #1;
        end
        reg_ack = 1'b0;
        xfer("post_stray", tv[8]);
        idle(1);

        // Reset asserted while the request is outstanding.
        @(posedge pclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 12'h030;
        pwrite  = 1'b0;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("mid_rst_req_before", 32'(reg_req), 32'd1);
        #1;
        preset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(reg_req), 32'd0);
        chk("mid_rst_rdy", 32'(pready), 32'd0);
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        chk("mid_rst_rdy2", 32'(pready), 32'd0);
        #1;
        preset_n = 1'b1;
        xfer("post_rst", tv[1]);
        idle(1);

        // Master drops psel while the request is pending.
        @(posedge pclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 12'h040;
        pwrite  = 1'b0;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        #1;
        chk("drop_req", 32'(reg_req), 32'd0);
        @(negedge pclk);
        chk("drop_rdy", 32'(pready), 32'd0);
        xfer("post_drop", tv[8]);
        idle(1);

        // Back-to-back write then erroring read, no idle between.
        xfer("b2b_wr", '{12'h004, 1'b1, 32'h0000_000A, 4'hF, 0,
                         32'h0, 1'b0, 2, 1, 1'b0, 32'h0, 4'hF});
        xfer("b2b_rd", '{12'h018, 1'b0, 32'h0, 4'h0, 0,
                         32'h0000_55AA, 1'b1, 2, 1, 1'b1,
                         32'h0000_55AA, 4'hF});
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
